thunderbird_lamp_monitor: RTL
=============================

Name: thunderbird_lamp_monitor

Overview:
- Receiving end of the Thunderbird tail-light interface: samples the six lamp lines (la, lb, lc, ra, rb, rc) on each lamp-update strobe.
- Decodes the running sequence (idle, left, right, hazard) and checks every step against the legal sequence grammar.
- Reports completed sequences, decoded mode and phase, and protocol faults.
- Sits beside the light controller in the top level, on the system clock, with the scaled-clock strobe as its sample enable. Used both as an on-board checker and as the bench scoreboard.

Parameters:
- CNT_W, 8, width of the saturating error counter err_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- step  input  1  one-cycle sample strobe; lamps are stable when it is high.
- clear  input  1  clears fault and err_count.
- la, lb, lc  input  1 each  left lamps, inner to outer.
- ra, rb, rc  input  1 each  right lamps, inner to outer.
- mode  output  2  00 idle, 01 left, 10 right, 11 hazard.
- phase  output  2  lamps lit in the current left/right sequence (0–3); 0 for idle and hazard.
- seq_done  output  1  one-cycle pulse when a left or right sequence completes.
- seq_dir  output  1  direction of the last completed sequence (0 = left, 1 = right); held between pulses.
- fault_pulse  output  1  one-cycle pulse on an illegal step.
- fault  output  1  sticky fault flag.
- err_count  output  CNT_W  saturating count of illegal steps.

Behaviour:
- Pattern mapping: L = {lc, lb, la}, R = {rc, rb, ra}. Recognised patterns:
  - IDLE: L = 000, R = 000.
  - L1/L2/L3: L = 001 / 011 / 111, with R = 000.
  - R1/R2/R3: R = 001 / 011 / 111, with L = 000.
  - HAZ: L = 111, R = 111.
  - Anything else is UNREC.
- FSM states: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
- Legal transitions, evaluated only when step = 1:
  - IDLE -> IDLE, L1, R1, or HAZ.
  - L1 -> L2, L2 -> L3, L3 -> IDLE.
  - R1 -> R2, R2 -> R3, R3 -> IDLE.
  - HAZ -> IDLE.
- Illegal step: a recognised pattern that is not a legal successor, or any UNREC pattern.
  - fault_pulse = 1 for one cycle.
  - fault set.
  - err_count increments, saturating at 2^CNT_W − 1.
  - State resyncs to the decoded pattern, or to IDLE if UNREC.
- Completion: the step L3 -> IDLE pulses seq_done with seq_dir = 0; the step R3 -> IDLE pulses seq_done with seq_dir = 1.
- Hazard alternation (IDLE <-> HAZ) never pulses seq_done.
- Latency: every output is registered. The state, mode, phase and pulse outputs reflect a step sample on the clock edge that samples it, i.e. visible the cycle after step is high.
- When step = 0: state and counters hold, pulses are 0, lamp inputs are ignored.
- clear:
  - clear = 1 with no illegal step in the same cycle: fault <= 0, err_count <= 0.
  - clear and an illegal step in the same cycle: the illegal step wins; fault <= 1, err_count <= 1.
  - clear does not affect the FSM state.
- Reset (asynchronous, any time, including mid-sequence): state IDLE, mode 00, phase 0, seq_done 0, seq_dir 0, fault_pulse 0, fault 0, err_count 0.
  - The first step after reset is judged from IDLE. Lamps showing L2 on that step are a fault and resync to L2.
- No timeout: a sequence may stall indefinitely between steps.

Decomposition:
- Package thunderbird_pkg:
  - FSM state enumeration (IDLE, L1–L3, R1–R3, HAZ, plus an UNREC code for the decoder).
  - Mode encodings: MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZ.
  - 3-bit lamp pattern constants: PAT_OFF = 000, PAT_1 = 001, PAT_2 = 011, PAT_3 = 111.
- Sub-module thunderbird_pattern_decode: combinational, maps the six lamp bits to a state code or UNREC.
- The monitor owns the legality check, the registers and the counters.

Test Plan:
- Reset, then steps with (L, R) = 000/000, 001/000, 011/000, 111/000, 000/000 -> mode 01, phase 1, 2, 3; seq_done = 1 with seq_dir = 0 exactly on the fifth step; fault stays 0.
- Mirrored right sequence -> seq_done = 1 with seq_dir = 1; mode 10 during the sequence; err_count = 0.
- Hazard: steps 111/111, 000/000 repeated 3 times -> mode alternates 11 / 00; seq_done never asserted; no fault.
- Illegal step: L1 then 111/000 (skips L2) -> fault_pulse for one cycle, fault = 1, err_count = 1, state L3; then 000/000 -> seq_done with seq_dir = 0.
- UNREC 010/000, then 001/001 -> two fault pulses, err_count = 2, state IDLE. Next: clear alone -> fault 0, count 0. Then clear together with an illegal step -> fault 1, err_count 1.
- Saturation and reset: CNT_W = 2, five illegal steps -> err_count = 3. Assert reset asynchronously mid-L2 (between clock edges) -> all outputs zero immediately; the next step with 001/000 is legal.

Source files
------------

// File: rtl/thunderbird_pkg.sv
// -----------------------------------------------------------------------------
// thunderbird_pkg
// Shared types and constants for the Thunderbird tail-light monitor:
//   - state_t   : sequence states plus the decoder-only UNREC code
//   - MODE_*    : 2-bit mode encodings reported on the mode output
//   - PAT_*     : 3-bit lamp patterns (inner to outer, bit 0 = inner lamp)
//   - helpers   : mode/phase extraction and the legal-successor grammar
// -----------------------------------------------------------------------------
package thunderbird_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_L1    = 4'd1,
      ST_L2    = 4'd2,
      ST_L3    = 4'd3,
      ST_R1    = 4'd4,
      ST_R2    = 4'd5,
      ST_R3    = 4'd6,
      ST_HAZ   = 4'd7,
      ST_UNREC = 4'd8
   } state_t;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_HAZ   = 2'b11;

   localparam logic [2:0] PAT_OFF = 3'b000;
   localparam logic [2:0] PAT_1   = 3'b001;
   localparam logic [2:0] PAT_2   = 3'b011;
   localparam logic [2:0] PAT_3   = 3'b111;

   // Mode reported for a given sequence state.
   function automatic logic [1:0] mode_of(input state_t s);
      case (s)
         ST_L1, ST_L2, ST_L3: mode_of = MODE_LEFT;
         ST_R1, ST_R2, ST_R3: mode_of = MODE_RIGHT;
         ST_HAZ:              mode_of = MODE_HAZ;
         default:             mode_of = MODE_IDLE;
      endcase
   endfunction

   // Number of lamps lit within a left/right sequence; 0 otherwise.
   function automatic logic [1:0] phase_of(input state_t s);
      case (s)
         ST_L1, ST_R1: phase_of = 2'd1;
         ST_L2, ST_R2: phase_of = 2'd2;
         ST_L3, ST_R3: phase_of = 2'd3;
         default:      phase_of = 2'd0;
      endcase
   endfunction

   // Legal-successor grammar; UNREC is never a legal successor.
   function automatic logic is_legal(input state_t cur, input state_t nxt);
      case (cur)
         ST_IDLE: is_legal = (nxt == ST_IDLE) || (nxt == ST_L1) ||
                             (nxt == ST_R1)   || (nxt == ST_HAZ);
         ST_L1:   is_legal = (nxt == ST_L2);
         ST_L2:   is_legal = (nxt == ST_L3);
         ST_L3:   is_legal = (nxt == ST_IDLE);
         ST_R1:   is_legal = (nxt == ST_R2);
         ST_R2:   is_legal = (nxt == ST_R3);
         ST_R3:   is_legal = (nxt == ST_IDLE);
         ST_HAZ:  is_legal = (nxt == ST_IDLE);
         default: is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/thunderbird_pattern_decode.sv
// -----------------------------------------------------------------------------
// thunderbird_pattern_decode
// Purely combinational: classifies the six lamp lines into a sequence state
// code, or ST_UNREC when the combination is not one of the recognised patterns.
// Ports:
//   i_la..i_lc : left lamps, inner to outer
//   i_ra..i_rc : right lamps, inner to outer
//   o_code     : decoded state_t code
// -----------------------------------------------------------------------------
module thunderbird_pattern_decode
   import thunderbird_pkg::*;
(
   input  logic   i_la,
   input  logic   i_lb,
   input  logic   i_lc,
   input  logic   i_ra,
   input  logic   i_rb,
   input  logic   i_rc,
   output state_t o_code
);

   logic [2:0] w_l;
   logic [2:0] w_r;

   assign w_l = {i_lc, i_lb, i_la};
   assign w_r = {i_rc, i_rb, i_ra};

   // Pattern classification; one side must be dark unless both are full (hazard).
   always_comb begin
      o_code = ST_UNREC;
      if ((w_l == PAT_OFF) && (w_r == PAT_OFF)) begin
         o_code = ST_IDLE;
      end else if ((w_l == PAT_3) && (w_r == PAT_3)) begin
         o_code = ST_HAZ;
      end else if (w_r == PAT_OFF) begin
         case (w_l)
            PAT_1:   o_code = ST_L1;
            PAT_2:   o_code = ST_L2;
            PAT_3:   o_code = ST_L3;
            default: o_code = ST_UNREC;
         endcase
      end else if (w_l == PAT_OFF) begin
         case (w_r)
            PAT_1:   o_code = ST_R1;
            PAT_2:   o_code = ST_R2;
            PAT_3:   o_code = ST_R3;
            default: o_code = ST_UNREC;
         endcase
      end else begin
         o_code = ST_UNREC;
      end
   end

endmodule

// File: rtl/thunderbird_lamp_monitor.sv
// -----------------------------------------------------------------------------
// thunderbird_lamp_monitor
// Samples the tail-light lamp lines on each step strobe, tracks the running
// sequence, flags illegal steps and reports completed left/right sequences.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   step              : one-cycle sample strobe (lamps stable while high)
//   clear             : clears fault and err_count (an illegal step wins)
//   la..lc, ra..rc    : lamp lines, inner to outer
//   mode, phase       : decoded mode and lit-lamp count of current state
//   seq_done, seq_dir : completion pulse and direction of last completion
//   fault_pulse       : one-cycle pulse on an illegal step
//   fault, err_count  : sticky fault flag and saturating illegal-step count
// All outputs are registered.
// -----------------------------------------------------------------------------
module thunderbird_lamp_monitor
   import thunderbird_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             clear,
   input  logic             la,
   input  logic             lb,
   input  logic             lc,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   output logic [1:0]       mode,
   output logic [1:0]       phase,
   output logic             seq_done,
   output logic             seq_dir,
   output logic             fault_pulse,
   output logic             fault,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] L_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_CNT_ZERO = CNT_W'(0);

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [1:0]       r_phase;
   logic             r_seq_done;
   logic             r_seq_dir;
   logic             r_fault_pulse;
   logic             r_fault;
   logic [CNT_W-1:0] r_err_count;

   state_t           w_code;
   state_t           w_next_state;
   logic             w_illegal;
   logic             w_done;
   logic             w_dir;

   thunderbird_pattern_decode u_decode (
      .i_la   (la),
      .i_lb   (lb),
      .i_lc   (lc),
      .i_ra   (ra),
      .i_rb   (rb),
      .i_rc   (rc),
      .o_code (w_code)
   );

   // Legality check and next-state selection for the current sample.
   always_comb begin
      w_next_state = r_state;
      w_illegal    = 1'b0;
      w_done       = 1'b0;
      w_dir        = r_seq_dir;
      if (step) begin
         if (w_code == ST_UNREC) begin
            // Unrecognised lamps: resync to a known-dark state.
            w_illegal    = 1'b1;
            w_next_state = ST_IDLE;
         end else begin
            // Always follow the lamps, legal or not, so one glitch costs one fault.
            w_illegal    = !is_legal(r_state, w_code);
            w_next_state = w_code;
            if (!w_illegal && (w_code == ST_IDLE) && (r_state == ST_L3)) begin
               w_done = 1'b1;
               w_dir  = 1'b0;
            end else if (!w_illegal && (w_code == ST_IDLE) && (r_state == ST_R3)) begin
               w_done = 1'b1;
               w_dir  = 1'b1;
            end else begin
               w_done = 1'b0;
               w_dir  = r_seq_dir;
            end
         end
      end else begin
         w_next_state = r_state;
         w_illegal    = 1'b0;
      end
   end

   // Sequence FSM with registered mode/phase, pulses, fault flag and counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_mode        <= MODE_IDLE;
         r_phase       <= 2'd0;
         r_seq_done    <= 1'b0;
         r_seq_dir     <= 1'b0;
         r_fault_pulse <= 1'b0;
         r_fault       <= 1'b0;
         r_err_count   <= L_CNT_ZERO;
      end else begin
         r_state       <= w_next_state;
         r_mode        <= mode_of(w_next_state);
         r_phase       <= phase_of(w_next_state);
         r_seq_done    <= w_done;
         r_seq_dir     <= w_dir;
         r_fault_pulse <= w_illegal;
         if (w_illegal) begin
            r_fault <= 1'b1;
            // A simultaneous clear restarts the count at this fault.
            if (clear) begin
               r_err_count <= L_CNT_ONE;
            end else if (r_err_count != L_CNT_MAX) begin
               r_err_count <= r_err_count + L_CNT_ONE;
            end else begin
               r_err_count <= r_err_count;
            end
         end else if (clear) begin
            r_fault     <= 1'b0;
            r_err_count <= L_CNT_ZERO;
         end else begin
            r_fault     <= r_fault;
            r_err_count <= r_err_count;
         end
      end
   end

   assign mode        = r_mode;
   assign phase       = r_phase;
   assign seq_done    = r_seq_done;
   assign seq_dir     = r_seq_dir;
   assign fault_pulse = r_fault_pulse;
   assign fault       = r_fault;
   assign err_count   = r_err_count;

endmodule
